// File: rtl/rdma_rx_arbiter_pkg.sv
// Shared definitions for the RDMA receive-path arbiter: FSM state encoding
// and the header layout constants used to check packet lengths.
package rdma_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Byte offset of the burst_len field inside the header beat (little-endian).
  localparam int BURST_LEN_BYTE = 50;

  // The header is beat number 1 of every packet (1-based).
  localparam int HEADER_BEAT = 1;

  // Beat counter width and its saturation value.
  localparam int BEAT_CNT_W = 9;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;

endpackage

// File: rtl/rdma_rx_arbiter_if.sv
// One AXI-Stream link as carried into and out of the arbiter.
// Handshake: a beat moves on a rising clk edge where tvalid && tready are both 1;
// a master holds tdata/tkeep/tlast stable while tvalid=1 and tready=0.
interface rdma_rx_arbiter_if #(
  parameter int DATA_WBITS = 512,
  parameter int DATA_WBYTS = DATA_WBITS / 8
);
  logic [DATA_WBITS-1:0] tdata;
  logic [DATA_WBYTS-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rdma_rx_arbiter.sv
// Packet-granular round-robin merge of two RDMA AXI-Stream inputs onto one
// output, with per-input packet counters and a header-vs-beat length check.
module rdma_rx_arbiter
  import rdma_pkg::*;
#(
  parameter int DATA_WBITS = 512,
  parameter int DATA_WBYTS = DATA_WBITS / 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WBITS-1:0] AXIS_IN0_TDATA,
  input  logic [DATA_WBYTS-1:0] AXIS_IN0_TKEEP,
  input  logic                  AXIS_IN0_TVALID,
  input  logic                  AXIS_IN0_TLAST,
  output logic                  AXIS_IN0_TREADY,
  input  logic [DATA_WBITS-1:0] AXIS_IN1_TDATA,
  input  logic [DATA_WBYTS-1:0] AXIS_IN1_TKEEP,
  input  logic                  AXIS_IN1_TVALID,
  input  logic                  AXIS_IN1_TLAST,
  output logic                  AXIS_IN1_TREADY,
  output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
  output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
  output logic                  AXIS_OUT_TVALID,
  output logic                  AXIS_OUT_TLAST,
  input  logic                  AXIS_OUT_TREADY,
  output logic [1:0]            grant,
  output logic [31:0]           pkt_count0,
  output logic [31:0]           pkt_count1,
  output logic [31:0]           len_err_count,
  output state_t                fsm_state
);

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  // Index of the input granted most recently; reset to 1 so input 0 wins first.
  logic                  rr_q, rr_d;
  logic                  pick;
  logic [BEAT_CNT_W-1:0] beat_q;
  logic [7:0]            burst_len_q;
  logic [31:0]           cnt0_q, cnt1_q, err_q;

  logic                  out_hs;
  logic                  hdr_beat;
  logic [7:0]            cur_burst_len;
  logic [BEAT_CNT_W:0]   beats_seen;
  logic [BEAT_CNT_W:0]   beats_expected;
  logic                  len_bad;

  assign grant         = grant_q;
  assign fsm_state     = state_q;
  assign pkt_count0    = cnt0_q;
  assign pkt_count1    = cnt1_q;
  assign len_err_count = err_q;

  // Datapath mux: granted input passes straight through in XFER, all zero in IDLE.
  always_comb begin
    AXIS_OUT_TDATA  = '0;
    AXIS_OUT_TKEEP  = '0;
    AXIS_OUT_TVALID = 1'b0;
    AXIS_OUT_TLAST  = 1'b0;
    AXIS_IN0_TREADY = 1'b0;
    AXIS_IN1_TREADY = 1'b0;
    if (state_q == ST_XFER) begin
      if (grant_q[0]) begin
        AXIS_OUT_TDATA  = AXIS_IN0_TDATA;
        AXIS_OUT_TKEEP  = AXIS_IN0_TKEEP;
        AXIS_OUT_TVALID = AXIS_IN0_TVALID;
        AXIS_OUT_TLAST  = AXIS_IN0_TLAST;
        AXIS_IN0_TREADY = AXIS_OUT_TREADY;
      end else begin
        AXIS_OUT_TDATA  = AXIS_IN1_TDATA;
        AXIS_OUT_TKEEP  = AXIS_IN1_TKEEP;
        AXIS_OUT_TVALID = AXIS_IN1_TVALID;
        AXIS_OUT_TLAST  = AXIS_IN1_TLAST;
        AXIS_IN1_TREADY = AXIS_OUT_TREADY;
      end
    end
  end

  assign out_hs = AXIS_OUT_TVALID & AXIS_OUT_TREADY;

  // Next state and grant: arbitrate in IDLE, hold the grant until the TLAST handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    pick    = (AXIS_IN0_TVALID & AXIS_IN1_TVALID) ? ~rr_q : AXIS_IN1_TVALID;
    case (state_q)
      ST_IDLE: begin
        if (AXIS_IN0_TVALID | AXIS_IN1_TVALID) begin
          state_d = ST_XFER;
          grant_d = pick ? 2'b10 : 2'b01;
          rr_d    = pick;
        end
      end
      ST_XFER: begin
        if (out_hs && AXIS_OUT_TLAST) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Length check: the header carries burst_len; a packet must be burst_len+2 beats.
  // A header that is also the last beat is always short.
  always_comb begin
    hdr_beat       = (beat_q == BEAT_CNT_W'(HEADER_BEAT - 1));
    cur_burst_len  = hdr_beat ? AXIS_OUT_TDATA[BURST_LEN_BYTE*8 +: 8] : burst_len_q;
    beats_seen     = {1'b0, beat_q} + 1'b1;
    beats_expected = {{(BEAT_CNT_W-7){1'b0}}, cur_burst_len} + (BEAT_CNT_W+1)'(2);
    len_bad        = hdr_beat || (beats_seen != beats_expected);
  end

  // FSM state, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Beat counter, latched burst_len and the wrapping statistics counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_q      <= '0;
      burst_len_q <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      err_q       <= '0;
    end else if (state_q == ST_IDLE) begin
      if (state_d == ST_XFER) beat_q <= '0;
    end else if (out_hs) begin
      if (beat_q != BEAT_CNT_MAX) beat_q <= beat_q + 1'b1;
      if (hdr_beat) burst_len_q <= AXIS_OUT_TDATA[BURST_LEN_BYTE*8 +: 8];
      if (AXIS_OUT_TLAST) begin
        if (grant_q[0]) cnt0_q <= cnt0_q + 32'd1;
        else            cnt1_q <= cnt1_q + 32'd1;
        if (len_bad)    err_q  <= err_q + 32'd1;
      end
    end
  end

endmodule
